spi_flash_erase_seq: RTL

//   Sequences one SPI NOR sector erase: WREN (0x06), then SE (0xD8 + 24-bit addr),

---
 rtl/spi_flash_erase_seq.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_erase_seq.sv
// SPI NOR sector-erase sequencer: WREN, SE + 24-bit address, then RDSR polling
// until WIP clears or the poll limit is hit. Includes its own mode-0 bit engine.
module spi_flash_erase_seq #(
   parameter int CLK_DIV  = 2,
   parameter int CS_GAP   = 4,
   parameter int POLL_MAX = 1000000
) (
   input  logic        sclk,
   input  logic        srst_n,
   input  logic        start,
   input  logic [23:0] addr,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  status,
   output logic        spi_clk,
   output logic        spi_cs,
   output logic        spi_do,
   input  logic        spi_di
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam int PW = $clog2(POLL_MAX + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
   localparam logic [PW-1:0] POLL_LIM = PW'(POLL_MAX);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WREN  = 3'd1,
      ST_GAP   = 3'd2,
      ST_SE    = 3'd3,
      ST_RDSR  = 3'd4,
      ST_CHECK = 3'd5,
      ST_FIN   = 3'd6
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic [23:0]     addr_r;
   logic [30:0]     tx_r;
   logic [7:0]      rx_r;
   logic [5:0]      bit_cnt_r;
   logic [DW-1:0]   div_cnt_r;
   logic [GW-1:0]   gap_cnt_r;
   logic            gap_to_se_r;
   logic [PW-1:0]   poll_cnt_r;
   logic            spi_cs_r;
   logic            spi_clk_r;
   logic            spi_do_r;
   logic            busy_r;
   logic            done_r;
   logic            err_r;
   logic [7:0]      status_r;

   logic            accept_s;
   logic            in_frame_s;
   logic            div_wrap_s;
   logic            frame_last_s;
   logic            frame_start_s;
   logic [PW-1:0]   poll_inc_s;
   logic            timeout_s;
   logic [31:0]     load_word_s;
   logic [5:0]      load_len_s;

   assign accept_s      = (state_r == ST_IDLE) && start;
   assign in_frame_s    = state_r inside {ST_WREN, ST_SE, ST_RDSR};
   assign div_wrap_s    = (div_cnt_r == DIV_LAST);
   // The last bit ends on the falling spi_clk edge; the frame closes on that same edge.
   assign frame_last_s  = in_frame_s && div_wrap_s && spi_clk_r && (bit_cnt_r == 6'd0);
   assign frame_start_s = (state_s != state_r) && (state_s inside {ST_WREN, ST_SE, ST_RDSR});
   assign poll_inc_s    = poll_cnt_r + PW'(1);
   assign timeout_s     = (poll_inc_s == POLL_LIM);

   // State register
   always_ff @(posedge sclk or negedge srst_n) begin
      if (!srst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_s = ST_WREN;
            else       state_s = ST_IDLE;
         end
         ST_WREN, ST_SE: begin
            if (frame_last_s) state_s = ST_GAP;
            else              state_s = state_r;
         end
         ST_GAP: begin
            if (gap_cnt_r == GAP_LAST) state_s = gap_to_se_r ? ST_SE : ST_RDSR;
            else                       state_s = ST_GAP;
         end
         ST_RDSR: begin
            if (frame_last_s) state_s = ST_CHECK;
            else              state_s = ST_RDSR;
         end
         ST_CHECK: begin
            if (!rx_r[0] || timeout_s) state_s = ST_FIN;
            else                       state_s = ST_GAP;
         end
         ST_FIN:  state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Frame contents, left-aligned so every frame shifts out MSB first from bit 31
   always_comb begin
      load_word_s = 32'h0000_0000;
      load_len_s  = 6'd0;
      case (state_s)
         ST_WREN: begin
            load_word_s = {8'h06, 24'h00_0000};
            load_len_s  = 6'd7;
         end
         ST_SE: begin
            load_word_s = {8'hD8, addr_r};
            load_len_s  = 6'd31;
         end
         ST_RDSR: begin
            load_word_s = {8'h05, 24'h00_0000};
            load_len_s  = 6'd15;
         end
         default: begin
            load_word_s = 32'h0000_0000;
            load_len_s  = 6'd0;
         end
      endcase
   end

   // SPI bit engine: divider, spi_clk phase, MOSI shift out and MISO shift in
   always_ff @(posedge sclk or negedge srst_n) begin
      if (!srst_n) begin
         spi_cs_r  <= 1'b1;
         spi_clk_r <= 1'b0;
         spi_do_r  <= 1'b0;
         tx_r      <= 31'd0;
         rx_r      <= 8'h00;
         bit_cnt_r <= 6'd0;
         div_cnt_r <= '0;
      end else if (frame_start_s) begin
         spi_cs_r  <= 1'b0;
         spi_clk_r <= 1'b0;
         spi_do_r  <= load_word_s[31];
         tx_r      <= load_word_s[30:0];
         bit_cnt_r <= load_len_s;
         div_cnt_r <= '0;
      end else if (in_frame_s && !frame_last_s) begin
         if (div_wrap_s) begin
            div_cnt_r <= '0;
            if (!spi_clk_r) begin
               spi_clk_r <= 1'b1;
               rx_r      <= {rx_r[6:0], spi_di};
            end else begin
               spi_clk_r <= 1'b0;
               bit_cnt_r <= bit_cnt_r - 6'd1;
               spi_do_r  <= tx_r[30];
               tx_r      <= {tx_r[29:0], 1'b0};
            end
         end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
         end
      end else begin
         spi_cs_r  <= 1'b1;
         spi_clk_r <= 1'b0;
         spi_do_r  <= 1'b0;
         div_cnt_r <= '0;
      end
   end

   // Sequence bookkeeping: latched address, gap timer, poll counter
   always_ff @(posedge sclk or negedge srst_n) begin
      if (!srst_n) begin
         addr_r      <= 24'h00_0000;
         gap_cnt_r   <= '0;
         gap_to_se_r <= 1'b0;
         poll_cnt_r  <= '0;
      end else begin
         if (accept_s) begin
            addr_r     <= addr;
            poll_cnt_r <= '0;
         end else if (state_r == ST_CHECK) begin
            poll_cnt_r <= poll_inc_s;
         end
         if (state_r == ST_WREN) begin
            gap_to_se_r <= 1'b1;
         end else if (state_r == ST_SE) begin
            gap_to_se_r <= 1'b0;
         end
         if ((state_r == ST_GAP) && (state_s == ST_GAP)) begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
         end else begin
            gap_cnt_r <= '0;
         end
      end
   end

   // Registered user-side outputs, decoded from the upcoming state
   always_ff @(posedge sclk or negedge srst_n) begin
      if (!srst_n) begin
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
         status_r <= 8'h00;
      end else begin
         busy_r <= (state_s != ST_IDLE) && (state_s != ST_FIN);
         done_r <= (state_s == ST_FIN);
         if (accept_s) begin
            err_r <= 1'b0;
         end else if ((state_r == ST_CHECK) && (state_s == ST_FIN)) begin
            err_r <= rx_r[0];
         end
         if (state_r == ST_CHECK) begin
            status_r <= rx_r;
         end
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign err     = err_r;
   assign status  = status_r;
   assign spi_clk = spi_clk_r;
   assign spi_cs  = spi_cs_r;
   assign spi_do  = spi_do_r;

endmodule
